vid_fetch: RTL and testbench

VID_FETCH -- requirements
Module: vid_fetch

---
 rtl/vid_fetch.sv | 220 ++++++++++++++++++++++
 tb/tb_vid_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_fetch.sv
// vid_fetch -- double-buffered display line fetcher for an MCB read port.
//
// Each frame it walks LINES consecutive 128-byte lines starting at the
// framebuffer base address. Every line is read with a single LINE_WORDS-beat
// MCB read command and lands in one of two line buffers. The display side
// reads the buffer that holds the oldest complete line. When it is done with
// that line, it hands the buffer back with line_done.
//
// Ports
//   clk, reset          memory-side clock, async active-high reset
//   calib_done          MCB calibrated; commands are held off while low
//   frame, base         start-of-frame pulse and framebuffer byte address
//   line_done           consumer has finished the displayed line
//   rd_adr, rd_data     32-bit display read port (registered, 1-cycle latency)
//   line_valid          display buffer holds a complete line
//   underrun            sticky: line_done seen with no valid line
//   cmd_*               MCB command port
//   rd_en, mcb_rd_data, rd_empty   MCB read FIFO
//
// FSM
//   IDLE | waiting for a free buffer, calibration and remaining lines
//   CMD  | presenting the read command until the command FIFO accepts it
//   XFER | popping LINE_WORDS words of the burst into the fill buffer

module vid_fetch #(
  parameter int LINES      = 768,
  parameter int LINE_WORDS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         calib_done,
  input  logic         frame,
  input  logic [23:0]  base,
  input  logic         line_done,
  input  logic [4:0]   rd_adr,
  output logic [31:0]  rd_data,
  output logic         line_valid,
  output logic         underrun,
  output logic         cmd_en,
  output logic [2:0]   cmd_instr,
  output logic [5:0]   cmd_bl,
  output logic [29:0]  cmd_byte_addr,
  input  logic         cmd_full,
  output logic         rd_en,
  input  logic [127:0] mcb_rd_data,
  input  logic         rd_empty
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LF_W  = $clog2(LINES + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [LF_W-1:0]  LINES_MAX = LF_W'(LINES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]       full, full_next;
  logic             fill_sel;
  logic             disp_sel;
  logic             discard;
  logic [16:0]      line_addr;
  logic [LF_W-1:0]  lines_fetched;
  logic [CNT_W-1:0] cnt;

  logic [127:0] line_buf [2][LINE_WORDS];
  logic [127:0] rd_word;

  logic last_pop;
  logic fill_done;
  logic disp_release;
  logic disp_underrun;

  // Sub-line byte offset of the base address is meaningless here.
  logic base_unused;
  assign base_unused = ^base[6:0];

  // Fixed command fields. The address tracks line_addr continuously. It is
  // only meaningful while cmd_en is high.
  assign cmd_bl        = 6'(LINE_WORDS - 1);
  assign cmd_byte_addr = {6'd0, line_addr, 7'd0};

  assign line_valid = full[disp_sel];

  // Frame restarts everything. Any completion or hand-back in that same cycle
  // belongs to the old frame and is dropped.
  assign last_pop      = rd_en && (cnt == LAST_WORD);
  assign fill_done     = last_pop && !discard && !frame;
  assign disp_release  = line_done && full[disp_sel] && !frame;
  assign disp_underrun = line_done && !full[disp_sel] && !frame;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (calib_done && !full[fill_sel] && (lines_fetched < LINES_MAX) && !frame)
          state_next = CMD;
      end
      CMD: begin
        if (frame)
          state_next = IDLE;
        else if (cmd_en)
          state_next = XFER;
      end
      XFER: begin
        if (last_pop)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_en    = 1'b0;
    cmd_instr = 3'b000;
    rd_en     = 1'b0;
    case (state)
      CMD: begin
        if (!frame && calib_done && !cmd_full) begin
          cmd_en    = 1'b1;
          cmd_instr = 3'b001;
        end
      end
      XFER: begin
        rd_en = !rd_empty;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- flags
  // The fill side only ever targets an empty buffer. The display side only
  // releases a full one. So a fill completion and a release in the same
  // cycle always touch different bits.
  always_comb begin
    full_next = full;
    if (frame) begin
      full_next = 2'b00;
    end else begin
      if (fill_done)
        full_next[fill_sel] = 1'b1;
      if (disp_release)
        full_next[disp_sel] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full          <= 2'b00;
      fill_sel      <= 1'b0;
      disp_sel      <= 1'b0;
      line_addr     <= 17'd0;
      lines_fetched <= '0;
      underrun      <= 1'b0;
      discard       <= 1'b0;
      cnt           <= '0;
    end else begin
      full <= full_next;

      if (rd_en)
        cnt <= (cnt == LAST_WORD) ? '0 : cnt + CNT_W'(1);

      if (frame) begin
        line_addr     <= base[23:7];
        lines_fetched <= '0;
        fill_sel      <= 1'b0;
        disp_sel      <= 1'b0;
        underrun      <= 1'b0;
        // A burst in flight belongs to the old frame. Drain it, but do not
        // let it count. If it finishes in this very cycle, there is nothing
        // left to drain.
        discard       <= (state == XFER) && !last_pop;
      end else begin
        if (fill_done) begin
          fill_sel      <= ~fill_sel;
          line_addr     <= line_addr + 17'd1;
          lines_fetched <= lines_fetched + LF_W'(1);
        end
        if (disp_release)
          disp_sel <= ~disp_sel;
        if (disp_underrun)
          underrun <= 1'b1;
        if (last_pop)
          discard <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- buffers
  // Buffer storage is not reset. Discarded beats are not written, so that a
  // stale burst cannot scribble over the new frame's first fill buffer.
  always_ff @(posedge clk) begin
    if (rd_en && !discard)
      line_buf[fill_sel][cnt] <= mcb_rd_data;
  end

  assign rd_word = line_buf[disp_sel][rd_adr[4:2]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 32'd0;
    end else begin
      rd_data <= rd_word[{rd_adr[1:0], 5'd0} +: 32];
    end
  end

endmodule

// File: tb/tb_vid_fetch.sv
// Directed testbench for vid_fetch (LINES=4, LINE_WORDS=8).
// The MCB read FIFO returns, for the n-th popped word, lanes
// K+4n .. K+4n+3. A line whose first pop is p0 therefore reads back
// K+4*p0+a at rd_adr a.

module tb_vid_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic         calib_done;
  logic         frame;
  logic [23:0]  base;
  logic         line_done;
  logic [4:0]   rd_adr;
  logic [31:0]  rd_data;
  logic         line_valid;
  logic         underrun;
  logic         cmd_en;
  logic [2:0]   cmd_instr;
  logic [5:0]   cmd_bl;
  logic [29:0]  cmd_byte_addr;
  logic         cmd_full;
  logic         rd_en;
  logic [127:0] mcb_rd_data;
  logic         rd_empty;

  int checks = 0;
  int errors = 0;
  int cmd_count = 0;
  int pop_count = 0;

  localparam logic [31:0] K = 32'hC0DE_0000;

  vid_fetch #(.LINES(4), .LINE_WORDS(8)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .frame(frame),
    .base(base), .line_done(line_done), .rd_adr(rd_adr), .rd_data(rd_data),
    .line_valid(line_valid), .underrun(underrun), .cmd_en(cmd_en),
    .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .rd_en(rd_en), .mcb_rd_data(mcb_rd_data),
    .rd_empty(rd_empty)
  );

  always #5 clk = ~clk;

  always_comb begin
    mcb_rd_data = {K + 32'(4 * pop_count + 3), K + 32'(4 * pop_count + 2),
                   K + 32'(4 * pop_count + 1), K + 32'(4 * pop_count)};
  end

  always @(posedge clk) begin
    if (cmd_en === 1'b1) cmd_count <= cmd_count + 1;
    if (rd_en === 1'b1)  pop_count <= pop_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input int budget, input string tag);
    int i = 0;
    while (cmd_en !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_seen"}, 64'(cmd_en), 64'd1);
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    int i = 0;
    while (pop_count < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_pops"}, 64'(pop_count), 64'(target));
  endtask

  task automatic read_line(input int p0, input string tag);
    for (int a = 0; a < 32; a++) begin
      rd_adr = 5'(a);
      @(negedge clk);
      check($sformatf("%s_adr%0d", tag, a), 64'(rd_data), 64'(K + 32'(4 * p0 + a)));
    end
  endtask

  task automatic pulse_line_done();
    line_done = 1'b1;
    @(negedge clk);
    line_done = 1'b0;
  endtask

  initial begin
    bit stall_ok;

    reset      = 1'b1;
    calib_done = 1'b0;
    frame      = 1'b0;
    base       = 24'd0;
    line_done  = 1'b0;
    rd_adr     = 5'd0;
    cmd_full   = 1'b0;
    rd_empty   = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_cmd_en",   64'(cmd_en), 64'd0);
    check("rst_rd_en",    64'(rd_en), 64'd0);
    check("rst_instr",    64'(cmd_instr), 64'd0);
    check("rst_bl",       64'(cmd_bl), 64'd7);
    check("rst_addr",     64'(cmd_byte_addr), 64'd0);
    check("rst_valid",    64'(line_valid), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_rd_data",  64'(rd_data), 64'd0);

    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("nocal_cmds", 64'(cmd_count), 64'd0);

    // Frame 1: base 0x0E7F00
    calib_done = 1'b1;
    frame      = 1'b1;
    base       = 24'h0E7F00;
    @(negedge clk);
    frame = 1'b0;
    wait_cmd(4, "cmd0");
    check("cmd0_addr",  64'(cmd_byte_addr), 64'h0E7F00);
    check("cmd0_bl",    64'(cmd_bl), 64'd7);
    check("cmd0_instr", 64'(cmd_instr), 64'd1);
    rd_empty = 1'b0;
    @(negedge clk);
    check("cmd0_pulse", 64'(cmd_en), 64'd0);
    check("cmd0_count", 64'(cmd_count), 64'd1);

    // Stall mid-burst
    wait_pops(3, 10, "l0a");
    rd_empty = 1'b1;
    stall_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rd_en !== 1'b0) stall_ok = 1'b0;
    end
    check("stall_rd_en", 64'(stall_ok), 64'd1);
    check("stall_pops",  64'(pop_count), 64'd3);
    check("stall_valid", 64'(line_valid), 64'd0);
    rd_empty = 1'b0;
    wait_pops(8, 10, "l0b");
    rd_empty = 1'b1;
    check("l0_valid", 64'(line_valid), 64'd1);
    wait_cmd(3, "cmd1");
    check("cmd1_addr", 64'(cmd_byte_addr), 64'h0E7F80);

    read_line(0, "rb_l0");
    rd_adr = 5'd5;
    #1;
    check("latency_hold", 64'(rd_data), 64'(K + 32'd31));
    @(negedge clk);
    check("latency_new", 64'(rd_data), 64'(K + 32'd5));

    // Line 1 -> both buffers full
    rd_empty = 1'b0;
    wait_pops(16, 12, "l1");
    rd_empty = 1'b1;
    check("l1_valid", 64'(line_valid), 64'd1);
    repeat (5) @(negedge clk);
    check("full_nocmd", 64'(cmd_count), 64'd2);

    pulse_line_done();
    check("ldA_valid", 64'(line_valid), 64'd1);
    wait_cmd(3, "cmd2");
    check("cmd2_addr", 64'(cmd_byte_addr), 64'h0E8000);
    read_line(8, "rb_l1");

    // Line 2: completion and hand-back in the same cycle
    rd_empty = 1'b0;
    wait_pops(23, 12, "l2a");
    line_done = 1'b1;
    @(negedge clk);
    line_done = 1'b0;
    rd_empty  = 1'b1;
    check("same_cyc_pops",  64'(pop_count), 64'd24);
    check("same_cyc_valid", 64'(line_valid), 64'd1);
    wait_cmd(3, "cmd3");
    check("cmd3_addr", 64'(cmd_byte_addr), 64'h0E8080);
    read_line(16, "rb_l2");

    // Line 3: last line of the frame
    rd_empty = 1'b0;
    wait_pops(32, 12, "l3");
    rd_empty = 1'b1;
    repeat (10) @(negedge clk);
    check("frame_cmds", 64'(cmd_count), 64'd4);
    check("l3_valid",   64'(line_valid), 64'd1);
    pulse_line_done();
    read_line(24, "rb_l3");
    pulse_line_done();
    check("drained_valid", 64'(line_valid), 64'd0);
    repeat (10) @(negedge clk);
    check("lines_limit", 64'(cmd_count), 64'd4);
    check("no_underrun", 64'(underrun), 64'd0);

    // Underrun
    pulse_line_done();
    check("underrun_set", 64'(underrun), 64'd1);
    repeat (5) @(negedge clk);
    check("underrun_sticky", 64'(underrun), 64'd1);
    check("underrun_valid",  64'(line_valid), 64'd0);

    // Frame 2: low address bits ignored, underrun cleared
    frame = 1'b1;
    base  = 24'h12345F;
    @(negedge clk);
    frame = 1'b0;
    check("frame_clr_underrun", 64'(underrun), 64'd0);
    wait_cmd(4, "cmd4");
    check("cmd4_addr", 64'(cmd_byte_addr), 64'h123400);
    rd_empty = 1'b0;
    @(negedge clk);
    check("cmd4_count", 64'(cmd_count), 64'd5);

    // Frame during XFER after 3 pops
    wait_pops(35, 10, "l4a");
    rd_empty = 1'b1;
    frame    = 1'b1;
    base     = 24'h200000;
    @(negedge clk);
    frame    = 1'b0;
    rd_empty = 1'b0;
    wait_pops(40, 12, "drain");
    rd_empty = 1'b1;
    check("discard_valid", 64'(line_valid), 64'd0);
    wait_cmd(3, "cmd5");
    check("cmd5_addr", 64'(cmd_byte_addr), 64'h200000);
    rd_empty = 1'b0;
    wait_pops(48, 12, "l5");
    rd_empty = 1'b1;
    cmd_full = 1'b1;
    check("l5_valid", 64'(line_valid), 64'd1);

    // Command FIFO full, then frame while in CMD
    repeat (3) @(negedge clk);
    check("cmdfull_en",    64'(cmd_en), 64'd0);
    check("cmdfull_count", 64'(cmd_count), 64'd6);
    frame    = 1'b1;
    base     = 24'h300000;
    cmd_full = 1'b0;
    #1;
    check("frame_in_cmd_en", 64'(cmd_en), 64'd0);
    @(negedge clk);
    frame = 1'b0;
    wait_cmd(3, "cmd6");
    check("cmd6_addr", 64'(cmd_byte_addr), 64'h300000);
    @(negedge clk);
    check("cmd6_count", 64'(cmd_count), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
